onehot_scan_encoder: RTL and testbench
======================================

// Module: onehot_scan_encoder
// PURPOSE
//   Encoder counterpart of the team's 3-to-8 decoder. Accepts an N-bit request
//   vector over a valid/ready handshake and emits the binary index of every set
//   bit, lowest index first, one index per beat on a valid/ready output stream.
//   Feeding each emitted index into the 3-to-8 decoder rebuilds the original vector.
// PARAMETERS
//   N  8           width of the input vector (power of 2, >= 2)
//   W  $clog2(N)   width of the output index (derived; 3 at default)
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  reset, asynchronous, active-low
//   in_valid   in   1  in_vec is valid
//   in_ready   out  1  block can capture a vector
//   in_vec     in   N  request vector; bit i set = index i requested
//   out_valid  out  1  out_idx/out_last/out_none are valid
//   out_ready  in   1  downstream consumes the current beat
//   out_idx    out  W  binary index of the current set bit
//   out_last   out  1  current beat is the final beat for this vector
//   out_none   out  1  captured vector was all-zero (single beat)
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-low.
// - Reset values: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0.
//   Internal pending vector=0, FSM=IDLE.
// - Reset mid-scan: asserting rst_n low clears all state immediately (async).
//   The remaining beats are discarded.
// - FSM states: IDLE and SCAN.
// - IDLE:
//   - in_ready=1 and out_valid=0.
//   - On in_valid&&in_ready, capture in_vec into pend and go to SCAN.
//   - The first beat is visible on the next cycle, so input-to-output latency is 1 clock.
// - SCAN:
//   - in_ready=0, out_valid=1.
//   - out_idx = index of the lowest set bit of pend.
//   - out_last=1 iff pend has exactly one set bit.
//   - All outputs are registered or decoded from registered state only. There is
//     no combinational path from in_* to out_*.
// - Beat transfer: on out_valid&&out_ready, clear that bit in pend.
//   - If out_last, go to IDLE, and in_ready=1 on the following cycle.
//   - Sustained throughput is 1 index/cycle while out_ready=1.
//   - An accepted K-bit vector occupies K+1 cycles from accept to in_ready high.
// - Stall: while out_valid&&!out_ready, out_idx/out_last/out_none hold stable.
// - Empty vector: in_vec==0 is still accepted. It produces exactly one beat with
//   out_none=1, out_idx=0, out_last=1. out_none=0 for all other beats.
// - Busy input: in_valid while in SCAN is ignored (in_ready=0). The upstream
//   must hold in_vec until accepted.
// - Full vector: all N bits set gives N beats, idx 0..N-1, with out_last on N-1.
// - Bits are emitted in strictly ascending index order; each set bit is emitted exactly once.
// TESTING
// - in_vec=8'b0000_0001, out_ready=1: one beat, idx=0, last=1, none=0.
//   in_ready returns to 1 two cycles after accept.
// - in_vec=8'b1010_0100, out_ready=1: beats idx=2,5,7 on consecutive cycles, last=1 only on 7.
// - in_vec=8'hFF, out_ready toggled 1/0 each cycle: idx 0..7 in order.
//   Each idx is held stable during its stall cycle; last=1 on 7.
// - in_vec=8'h00: single beat, none=1, idx=0, last=1; then back to IDLE.
// - Accept 8'h81, then drive in_valid=1 with 8'h02 during the scan: in_ready=0
//   for both beats (0, 7). 8'h02 is accepted only after the last beat, then idx=1.
// - Accept 8'hF0, consume idx=4, pull rst_n low mid-cycle: out_valid=0 and
//   in_ready=1 immediately. No further beats after release.

Source files
------------

// File: rtl/onehot_scan_encoder.sv
// rtl/onehot_scan_encoder.sv - scans a captured request vector and streams the index of each set bit, lowest first
module onehot_scan_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic [N-1:0]   pend_q,      pend_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_idx_q,   out_idx_d;
    logic           out_last_q,  out_last_d;
    logic           out_none_q,  out_none_d;

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic logic [W-1:0] low_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = W'(i);
            end
        end
        return r;
    endfunction

    // True when at most one bit is set (zero counts, so the empty beat is last).
    function automatic logic at_most_one(input logic [N-1:0] v);
        return (v & (v - N'(1))) == '0;
    endfunction

    // Next-state logic; outputs are precomputed from the next pending vector so they leave flops.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_none_d  = out_none_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d     = in_vec;
                    state_d    = SCAN;
                    out_none_d = (in_vec == '0);
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d    = IDLE;
                        pend_d     = '0;
                        out_none_d = 1'b0;
                    end else begin
                        // Clear the lowest set bit, i.e. the one just emitted.
                        pend_d = pend_q & (pend_q - N'(1));
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                pend_d     = '0;
                out_none_d = 1'b0;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SCAN);
        out_idx_d   = (state_d == SCAN) ? low_idx(pend_d) : '0;
        out_last_d  = (state_d == SCAN) && at_most_one(pend_d);
    end

    // Single state register for the FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_none_q  <= out_none_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_none  = out_none_q;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// tb/tb_onehot_scan_encoder.sv - directed self-checking bench for onehot_scan_encoder
module tb_onehot_scan_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_none;

    int total;
    int bad;
    int exp_q[$];

    onehot_scan_encoder #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present a vector in IDLE and let the next rising edge accept it.
    task automatic send(input logic [7:0] v);
        @(negedge clk);
        chk("send_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Consume the beats listed in exp_q; optionally stall every other cycle.
    task automatic collect(input string tag, input bit toggle, input bit exp_none);
        int  beat;
        int  n;
        bit  phase;
        beat  = 0;
        n     = exp_q.size();
        phase = 1'b1;
        for (int cyc = 0; cyc < 100 && beat < n; cyc++) begin
            @(negedge clk);
            out_ready = toggle ? phase : 1'b1;
            phase     = ~phase;
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_in_ready"}, 32'(in_ready), 0);
            chk({tag, "_idx"}, 32'(out_idx), 32'(exp_q[beat]));
            chk({tag, "_last"}, 32'(out_last), 32'(beat == n - 1));
            chk({tag, "_none"}, 32'(out_none), 32'(exp_none));
            if (out_ready) beat++;
        end
        chk({tag, "_beats"}, 32'(beat), 32'(n));
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, "_end_valid"}, 32'(out_valid), 0);
        chk({tag, "_end_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_none", 32'(out_none), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single bit: one beat, in_ready back two cycles after accept.
        send(8'b0000_0001);
        exp_q = '{0};
        collect("one", 1'b0, 1'b0);

        // Sparse vector, back-to-back beats.
        send(8'b1010_0100);
        exp_q = '{2, 5, 7};
        collect("sparse", 1'b0, 1'b0);

        // Full vector with out_ready alternating; each beat must hold through its stall.
        send(8'hFF);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        collect("full", 1'b1, 1'b0);

        // Empty vector: single none beat.
        send(8'h00);
        exp_q = '{0};
        collect("empty", 1'b0, 1'b1);

        // Busy input: second vector held during scan, accepted only afterwards.
        send(8'h81);
        in_valid = 1'b1;
        in_vec   = 8'h02;
        exp_q = '{0, 7};
        collect("busy", 1'b0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_q = '{1};
        collect("after_busy", 1'b0, 1'b0);

        // Async reset in the middle of a scan.
        send(8'hF0);
        @(negedge clk);
        out_ready = 1'b1;
        chk("rst_mid_idx4", 32'(out_idx), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", 32'(out_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
